ex_mem_register: RTL and testbench
==================================

# ex_mem_register

Pipeline register between the execute stage (the 16-bit ALU) and the memory stage of the CPU. It captures the ALU result, store data, destination register and control bits every cycle. It holds the architectural N/Z flag register, written by flag-setting instructions. It resolves conditional branches against those flags and supports stall and flush from the hazard unit.

## Interface
Parameters:
- DATA_W, 16: datapath width; matches ALUresult/srcA/srcB.
- REG_ADDR_W, 4: register file address width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold all registered state this cycle.
- flush  in  1  replace the captured instruction with a bubble.
- ex_valid  in  1  EX slot holds a real instruction.
- ex_ALUresult  in  DATA_W  ALU output.
- ex_flagN, ex_flagZ  in  1 each  ALU flags.
- ex_setFlags  in  1  instruction updates the flag register.
- ex_storeData  in  DATA_W  register value for memory store.
- ex_rd  in  REG_ADDR_W  destination register.
- ex_regWrite, ex_memWrite, ex_memToReg  in  1 each  control bits.
- ex_branch  in  1  instruction is a branch.
- ex_cond  in  2  branch condition: 00 always, 01 EQ (Z=1), 10 NE (Z=0), 11 LT (N=1).
- mem_valid  out  1  MEM slot valid.
- mem_ALUresult, mem_storeData  out  DATA_W  registered copies.
- mem_rd  out  REG_ADDR_W  registered destination.
- mem_regWrite, mem_memWrite, mem_memToReg  out  1 each  registered control; forced 0 when mem_valid=0.
- mem_branchTaken  out  1  registered branch decision.
- flagN_q, flagZ_q  out  1 each  architectural flag register.

## Operation
- Per-cycle priority: rst > flush > stall > load.
- Load (no flush, no stall):
  - All mem_* outputs take the corresponding ex_* values.
  - mem_valid <= ex_valid.
  - Control outputs are gated with ex_valid.
- Stall:
  - Every register holds, including flagN_q/flagZ_q.
  - Inputs are ignored.
- Flush:
  - mem_valid, mem_regWrite, mem_memWrite, mem_memToReg and mem_branchTaken go to 0.
  - Data fields (mem_ALUresult, mem_storeData, mem_rd) are don't-care and may load.
  - The flag register does not update.
- flush and stall both asserted: flush wins.
- Flag register:
  - Updates to {ex_flagN, ex_flagZ} only when ex_valid && ex_setFlags && !stall && !flush.
  - Otherwise it holds.
- Branch resolution:
  - mem_branchTaken <= ex_valid && ex_branch && cond_met.
  - cond_met is computed from flagN_q/flagZ_q as they are before this edge.
  - An instruction with both ex_setFlags and ex_branch evaluates against the old flags.
- No arithmetic is performed here; widths pass through unchanged.

## Timing
- Latency: one cycle, EX inputs to mem_* outputs.
- Flag write is visible on flagN_q/flagZ_q in the cycle after the setting instruction.
- A branch in the next EX cycle sees the updated flags (no bypass required).
- Reset: all outputs 0 immediately on rst assertion (asynchronous), independent of clk.
  - This covers mem_valid, mem_ALUresult, mem_storeData, mem_rd, all control bits, mem_branchTaken, flagN_q and flagZ_q.
- Reset deassertion mid-stream: the first clk edge with rst=0 loads normally.
- A stall lasting N cycles holds the outputs for exactly N cycles. The held instruction appears exactly once in MEM.

## Configuration
- Macro: EX_MEM_PERF_COUNT_EN.
- Defined: two DATA_W-bit saturating counters, output as ports stall_cnt and flush_cnt.
  - stall_cnt increments on each cycle with stall && !flush.
  - flush_cnt increments on each cycle with flush.
  - Both saturate at all-ones and reset to 0.
- Not defined: counters and their ports are absent; all other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - the branch condition encoding as an enum (COND_AL, COND_EQ, COND_NE, COND_LT);
  - DATA_W and REG_ADDR_W defaults;
  - a packed struct ex_mem_ctrl_t with fields regWrite, memWrite, memToReg.
- One sub-module: cond_eval. It is combinational, takes ex_cond, N and Z, and produces cond_met; the future branch unit reuses it.

## Test plan
- Reset: assert rst mid-cycle with mem_valid=1 and flags=11 -> all outputs 0 before the next clk edge.
- Load: ex_ALUresult=3, ex_rd=5, ex_regWrite=1, ex_valid=1 -> next cycle mem_ALUresult=3, mem_rd=5, mem_regWrite=1, mem_valid=1.
- Flags and branch:
  - Cycle 0: compare 5−5 with ex_setFlags=1, Z=1.
  - Cycle 1: branch with ex_cond=01.
  - Expected: flagZ_q=1 after cycle 0; mem_branchTaken=1 after cycle 1.
  - Repeat with ex_cond=10 -> mem_branchTaken=0.
- Stall: stall held 3 cycles with changing inputs -> mem_* and flags unchanged for 3 cycles, then load the current inputs.
- Flush priority: flush=1, stall=1, ex_valid=1, ex_setFlags=1, N=1 -> mem_valid=0, all control 0, flagN_q unchanged.
- With EX_MEM_PERF_COUNT_EN: 2 stall cycles, then 1 flush+stall cycle -> stall_cnt=2, flush_cnt=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, branch condition encoding, EX/MEM control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int CPU_DATA_W     = 16;
    localparam int CPU_REG_ADDR_W = 4;

    // Branch condition field carried with branch instructions.
    typedef enum logic [1:0] {
        COND_AL = 2'b00,  // always
        COND_EQ = 2'b01,  // Z set
        COND_NE = 2'b10,  // Z clear
        COND_LT = 2'b11   // N set
    } cond_t;

    // Control bits that travel with an instruction into the memory stage.
    typedef struct packed {
        logic regWrite;
        logic memWrite;
        logic memToReg;
    } ex_mem_ctrl_t;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: maps a condition code and N/Z flags to a taken/not-taken bit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   cond     - 2-bit condition code (cond_t encoding)
//   n, z     - flag values to test against
//   cond_met - 1 when the condition holds
module cond_eval
    import cpu_pkg::*;
(
    input  logic [1:0] cond,
    input  logic       n,
    input  logic       z,
    output logic       cond_met
);

    always_comb begin
        cond_met = 1'b0;
        case (cond_t'(cond))
            COND_AL: cond_met = 1'b1;
            COND_EQ: cond_met = z;
            COND_NE: cond_met = !z;
            COND_LT: cond_met = n;
            default: cond_met = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with architectural N/Z flag register and branch resolution.
// Latency: one cycle from ex_* inputs to mem_* outputs; flag writes visible the next cycle.
// Backpressure: stall holds every register (flags included); flush inserts a bubble and overrides stall.
//
// Ports:
//   clk, rst                 - core clock, asynchronous active-high reset
//   stall, flush             - hazard unit controls (flush has priority)
//   ex_*                     - execute-stage instruction fields
//   mem_*                    - registered memory-stage copies; control bits are 0 whenever mem_valid=0
//   flagN_q, flagZ_q         - architectural flag register
//   stall_cnt, flush_cnt     - saturating event counters, present only with EX_MEM_PERF_COUNT_EN defined
module ex_mem_register
    import cpu_pkg::*;
#(
    parameter int DATA_W     = CPU_DATA_W,
    parameter int REG_ADDR_W = CPU_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_ALUresult,
    input  logic                  ex_flagN,
    input  logic                  ex_flagZ,
    input  logic                  ex_setFlags,
    input  logic [DATA_W-1:0]     ex_storeData,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_regWrite,
    input  logic                  ex_memWrite,
    input  logic                  ex_memToReg,
    input  logic                  ex_branch,
    input  logic [1:0]            ex_cond,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_ALUresult,
    output logic [DATA_W-1:0]     mem_storeData,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_regWrite,
    output logic                  mem_memWrite,
    output logic                  mem_memToReg,
    output logic                  mem_branchTaken,
`ifdef EX_MEM_PERF_COUNT_EN
    output logic [DATA_W-1:0]     stall_cnt,
    output logic [DATA_W-1:0]     flush_cnt,
`endif
    output logic                  flagN_q,
    output logic                  flagZ_q
);

    ex_mem_ctrl_t ctrl_d;
    ex_mem_ctrl_t ctrl_q;
    logic         cond_met;
    logic         data_en;

    // Branches are resolved against the flags as they stand before this edge,
    // so a flag-setting branch sees the previous flag values.
    cond_eval u_cond_eval (
        .cond     (ex_cond),
        .n        (flagN_q),
        .z        (flagZ_q),
        .cond_met (cond_met)
    );

    // Control bits are gated with ex_valid so a bubble never carries side effects.
    always_comb begin
        ctrl_d          = '0;
        ctrl_d.regWrite = ex_valid & ex_regWrite;
        ctrl_d.memWrite = ex_valid & ex_memWrite;
        ctrl_d.memToReg = ex_valid & ex_memToReg;
    end

    // Data fields are don't-care under flush, so they load whenever the
    // stage is not held; only a pure stall freezes them.
    assign data_en = !stall || flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid       <= 1'b0;
            ctrl_q          <= '0;
            mem_branchTaken <= 1'b0;
            mem_ALUresult   <= '0;
            mem_storeData   <= '0;
            mem_rd          <= '0;
            flagN_q         <= 1'b0;
            flagZ_q         <= 1'b0;
        end else begin
            if (flush) begin
                mem_valid       <= 1'b0;
                ctrl_q          <= '0;
                mem_branchTaken <= 1'b0;
            end else if (!stall) begin
                mem_valid       <= ex_valid;
                ctrl_q          <= ctrl_d;
                mem_branchTaken <= ex_valid & ex_branch & cond_met;
                if (ex_valid && ex_setFlags) begin
                    flagN_q <= ex_flagN;
                    flagZ_q <= ex_flagZ;
                end
            end
            if (data_en) begin
                mem_ALUresult <= ex_ALUresult;
                mem_storeData <= ex_storeData;
                mem_rd        <= ex_rd;
            end
        end
    end

    assign mem_regWrite = ctrl_q.regWrite;
    assign mem_memWrite = ctrl_q.memWrite;
    assign mem_memToReg = ctrl_q.memToReg;

`ifdef EX_MEM_PERF_COUNT_EN
    // Counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !flush && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + DATA_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + DATA_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_register.sv
// Directed bench for ex_mem_register with a queue-based scoreboard fed by a reference model.
// Latency: checks one cycle after each driven EX slot.
// Backpressure: exercises stall, flush and flush-over-stall.
module tb_ex_mem_register;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [15:0] ex_ALUresult;
    logic        ex_flagN;
    logic        ex_flagZ;
    logic        ex_setFlags;
    logic [15:0] ex_storeData;
    logic [3:0]  ex_rd;
    logic        ex_regWrite;
    logic        ex_memWrite;
    logic        ex_memToReg;
    logic        ex_branch;
    logic [1:0]  ex_cond;
    logic        mem_valid;
    logic [15:0] mem_ALUresult;
    logic [15:0] mem_storeData;
    logic [3:0]  mem_rd;
    logic        mem_regWrite;
    logic        mem_memWrite;
    logic        mem_memToReg;
    logic        mem_branchTaken;
    logic        flagN_q;
    logic        flagZ_q;
`ifdef EX_MEM_PERF_COUNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    ex_mem_register #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .ex_valid        (ex_valid),
        .ex_ALUresult    (ex_ALUresult),
        .ex_flagN        (ex_flagN),
        .ex_flagZ        (ex_flagZ),
        .ex_setFlags     (ex_setFlags),
        .ex_storeData    (ex_storeData),
        .ex_rd           (ex_rd),
        .ex_regWrite     (ex_regWrite),
        .ex_memWrite     (ex_memWrite),
        .ex_memToReg     (ex_memToReg),
        .ex_branch       (ex_branch),
        .ex_cond         (ex_cond),
        .mem_valid       (mem_valid),
        .mem_ALUresult   (mem_ALUresult),
        .mem_storeData   (mem_storeData),
        .mem_rd          (mem_rd),
        .mem_regWrite    (mem_regWrite),
        .mem_memWrite    (mem_memWrite),
        .mem_memToReg    (mem_memToReg),
        .mem_branchTaken (mem_branchTaken),
`ifdef EX_MEM_PERF_COUNT_EN
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
`endif
        .flagN_q         (flagN_q),
        .flagZ_q         (flagZ_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk_data;
        logic        valid;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [3:0]  rd;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        bt;
        logic        n;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic cond_ok(input logic [1:0] c, input logic n, input logic z);
        case (c)
            2'd0:    return 1'b1;
            2'd1:    return z;
            2'd2:    return !z;
            default: return n;
        endcase
    endfunction

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(mem_valid), 32'(e.valid));
        chk({tag, ".regWrite"}, 32'(mem_regWrite), 32'(e.rw));
        chk({tag, ".memWrite"}, 32'(mem_memWrite), 32'(e.mw));
        chk({tag, ".memToReg"}, 32'(mem_memToReg), 32'(e.m2r));
        chk({tag, ".branchTaken"}, 32'(mem_branchTaken), 32'(e.bt));
        chk({tag, ".flagN"}, 32'(flagN_q), 32'(e.n));
        chk({tag, ".flagZ"}, 32'(flagZ_q), 32'(e.z));
        if (e.chk_data) begin
            chk({tag, ".ALUresult"}, 32'(mem_ALUresult), 32'(e.alu));
            chk({tag, ".storeData"}, 32'(mem_storeData), 32'(e.sd));
            chk({tag, ".rd"}, 32'(mem_rd), 32'(e.rd));
        end
    endtask

    // Predict the next MEM state from current inputs, advance one edge, compare.
    task automatic tick(input string tag);
        exp_t nx;
        exp_t got;
        nx = m;
        nx.chk_data = 1'b1;
        if (flush) begin
            nx.valid = 1'b0;
            nx.rw = 1'b0; nx.mw = 1'b0; nx.m2r = 1'b0; nx.bt = 1'b0;
            nx.chk_data = 1'b0;
        end else if (!stall) begin
            nx.valid = ex_valid;
            nx.alu   = ex_ALUresult;
            nx.sd    = ex_storeData;
            nx.rd    = ex_rd;
            nx.rw    = ex_valid && ex_regWrite;
            nx.mw    = ex_valid && ex_memWrite;
            nx.m2r   = ex_valid && ex_memToReg;
            nx.bt    = ex_valid && ex_branch && cond_ok(ex_cond, m.n, m.z);
            if (ex_valid && ex_setFlags) begin
                nx.n = ex_flagN;
                nx.z = ex_flagZ;
            end
        end
        exp_q.push_back(nx);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            chk_all(tag, got);
            m = got;
            // Data registers load under flush; track them so later holds compare correctly.
            if (!got.chk_data) begin
                m.alu = mem_ALUresult;
                m.sd  = mem_storeData;
                m.rd  = mem_rd;
            end
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; ex_valid = 0; ex_ALUresult = '0; ex_flagN = 0; ex_flagZ = 0;
        ex_setFlags = 0; ex_storeData = '0; ex_rd = '0; ex_regWrite = 0; ex_memWrite = 0;
        ex_memToReg = 0; ex_branch = 0; ex_cond = 2'b00;
    endtask

    task automatic chk_reset_zero(input string tag);
        chk({tag, ".valid"}, 32'(mem_valid), 32'd0);
        chk({tag, ".ALUresult"}, 32'(mem_ALUresult), 32'd0);
        chk({tag, ".storeData"}, 32'(mem_storeData), 32'd0);
        chk({tag, ".rd"}, 32'(mem_rd), 32'd0);
        chk({tag, ".regWrite"}, 32'(mem_regWrite), 32'd0);
        chk({tag, ".memWrite"}, 32'(mem_memWrite), 32'd0);
        chk({tag, ".memToReg"}, 32'(mem_memToReg), 32'd0);
        chk({tag, ".branchTaken"}, 32'(mem_branchTaken), 32'd0);
        chk({tag, ".flagN"}, 32'(flagN_q), 32'd0);
        chk({tag, ".flagZ"}, 32'(flagZ_q), 32'd0);
`ifdef EX_MEM_PERF_COUNT_EN
        chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'd0);
        chk({tag, ".flush_cnt"}, 32'(flush_cnt), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        m = '0;
        #2;
        chk_reset_zero("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Plain load
        ex_valid = 1; ex_ALUresult = 16'd3; ex_rd = 4'd5; ex_regWrite = 1; ex_storeData = 16'h00aa;
        tick("load");
        chk("load.alu_is_3", 32'(mem_ALUresult), 32'd3);
        chk("load.rd_is_5", 32'(mem_rd), 32'd5);

        // Compare 5-5 sets Z, then EQ branch is taken
        ex_regWrite = 0; ex_ALUresult = 16'd0; ex_setFlags = 1; ex_flagZ = 1; ex_flagN = 0;
        tick("cmp_eq");
        chk("cmp_eq.flagZ_set", 32'(flagZ_q), 32'd1);
        ex_setFlags = 0; ex_flagZ = 0; ex_branch = 1; ex_cond = 2'b01;
        tick("br_eq");
        chk("br_eq.taken", 32'(mem_branchTaken), 32'd1);
        ex_cond = 2'b10;
        tick("br_ne");
        chk("br_ne.not_taken", 32'(mem_branchTaken), 32'd0);

        // Flag-setting branch sees old flags (N=0), next LT sees N=1
        ex_cond = 2'b11; ex_setFlags = 1; ex_flagN = 1; ex_flagZ = 0;
        tick("br_lt_old_flags");
        ex_setFlags = 0;
        tick("br_lt_new_flags");
        ex_cond = 2'b00;
        tick("br_always");

        // Invalid slot: controls, branch and flag write suppressed
        ex_valid = 0; ex_regWrite = 1; ex_memWrite = 1; ex_memToReg = 1; ex_setFlags = 1;
        ex_flagN = 0; ex_flagZ = 1; ex_ALUresult = 16'h1234;
        tick("bubble_in");

        // Stall three cycles with changing inputs, then load
        ex_valid = 1; ex_memWrite = 1; ex_regWrite = 0; ex_memToReg = 0; ex_branch = 0;
        ex_setFlags = 0; ex_ALUresult = 16'h0bee; ex_storeData = 16'h5a5a; ex_rd = 4'd9;
        tick("pre_stall");
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            ex_valid     = 1'($urandom);
            ex_ALUresult = 16'($urandom);
            ex_storeData = 16'($urandom);
            ex_rd        = 4'($urandom);
            ex_regWrite  = 1'($urandom);
            ex_setFlags  = 1;
            ex_flagN     = 1'($urandom);
            ex_flagZ     = 1'($urandom);
            ex_branch    = 1;
            tick($sformatf("stall%0d", i));
        end
        stall = 0;
        ex_valid = 1; ex_ALUresult = 16'hc0de; ex_rd = 4'd2; ex_setFlags = 1; ex_flagN = 0; ex_flagZ = 0;
        tick("stall_release");

        // Flush wins over stall; flags untouched
        ex_valid = 1; ex_regWrite = 1; ex_memWrite = 1; ex_memToReg = 1; ex_branch = 1; ex_cond = 2'b00;
        ex_setFlags = 1; ex_flagN = 1; ex_flagZ = 1;
        flush = 1; stall = 1;
        tick("flush_stall");
        chk("flush_stall.flagN_held", 32'(flagN_q), 32'd0);
        stall = 0;
        tick("flush_only");

        // Fill state (valid, flags=11), then asynchronous reset mid-cycle
        flush = 0; ex_setFlags = 1; ex_flagN = 1; ex_flagZ = 1; ex_ALUresult = 16'hffff; ex_storeData = 16'h7777;
        tick("prefill");
        #2;
        rst = 1'b1;
        #1;
        chk_reset_zero("reset_async");
        #2;
        rst = 1'b0;
        m = '0;
        ex_setFlags = 0; ex_ALUresult = 16'h0042; ex_rd = 4'd15;
        tick("post_reset_load");

`ifdef EX_MEM_PERF_COUNT_EN
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m = '0;
        stall = 1;
        tick("perf_stall0");
        tick("perf_stall1");
        flush = 1;
        tick("perf_flush_stall");
        chk("perf.stall_cnt", 32'(stall_cnt), 32'd2);
        chk("perf.flush_cnt", 32'(flush_cnt), 32'd1);
        flush = 0; stall = 0;
`endif

        idle_inputs();
        tick("drain");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
